// File: rtl/vr_ni_pkg.sv
// Shared definitions for the VC flit injector.
// Contents:
//   state_t    - transmitter FSM states (IDLE, SEND)
//   DEF_*      - field layout of the default flit configuration
//   pack_flit  - assembles {vc, dest, payload} for any field widths
`ifndef FLIT_DATA_WIDTH
`define FLIT_DATA_WIDTH 32
`endif

package vr_ni_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Widest flit pack_flit can assemble; callers truncate to their FLIT_W.
    localparam int PACK_MAX_W = 128;

    // Field offsets of the default layout (NUM_VC=4, ROUTER_ID_BITS=4).
    localparam int DEF_FLIT_W      = `FLIT_DATA_WIDTH;
    localparam int DEF_VC_BITS     = 2;
    localparam int DEF_ID_BITS     = 4;
    localparam int DEF_PAYLOAD_LSB = 0;
    localparam int DEF_DEST_LSB    = DEF_FLIT_W - DEF_VC_BITS - DEF_ID_BITS;
    localparam int DEF_VC_LSB      = DEF_FLIT_W - DEF_VC_BITS;

    // The payload occupies [dest_lsb-1:0], dest sits above it and vc on top.
    function automatic logic [PACK_MAX_W-1:0] pack_flit(
        input logic [PACK_MAX_W-1:0] vc,
        input logic [PACK_MAX_W-1:0] dest,
        input logic [PACK_MAX_W-1:0] payload,
        input int unsigned           dest_lsb,
        input int unsigned           vc_lsb
    );
        logic [PACK_MAX_W-1:0] mask;
        mask = (PACK_MAX_W'(1) << dest_lsb) - PACK_MAX_W'(1);
        return (vc << vc_lsb) | (dest << dest_lsb) | (payload & mask);
    endfunction

endpackage

// File: rtl/vc_credit_counter.sv
// Credit counter for one downstream VC buffer.
// Ports:
//   clk, reset_n - clock, asynchronous active-low reset (count -> BUF_DEPTH)
//   inc          - one credit returned by the router this cycle
//   dec          - one flit sent on this VC this cycle (only issued when count > 0)
//   count        - credits currently available
//   overflow     - sticky; set when a credit arrives while already full with no send
module vc_credit_counter #(
    parameter int BUF_DEPTH   = 4,
    parameter int CREDIT_BITS = $clog2(BUF_DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   inc,
    input  logic                   dec,
    output logic [CREDIT_BITS-1:0] count,
    output logic                   overflow
);

    localparam logic [CREDIT_BITS-1:0] FULL = CREDIT_BITS'(BUF_DEPTH);

    // Simultaneous return and send cancel; otherwise step and clamp to [0, FULL].
    function automatic logic [CREDIT_BITS-1:0] sat_next(
        input logic [CREDIT_BITS-1:0] cur,
        input logic                   up,
        input logic                   down
    );
        logic [CREDIT_BITS-1:0] nxt;
        nxt = cur;
        if (up && !down) begin
            if (cur != FULL) nxt = cur + 1'b1;
        end else if (down && !up) begin
            if (cur != '0) nxt = cur - 1'b1;
        end
        return nxt;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count    <= FULL;
            overflow <= 1'b0;
        end else begin
            count <= sat_next(count, inc, dec);
            if (inc && !dec && (count == FULL)) overflow <= 1'b1;
        end
    end

endmodule

// File: rtl/vc_flit_injector.sv
// Network-interface transmitter feeding one router input port.
// Accepts payload beats, binds each packet to a downstream VC picked
// round-robin among VCs with credit, and emits one flit per accepted beat,
// only while the bound VC holds credit.
// Ports:
//   clk, reset_n      - clock, asynchronous active-low reset
//   in_valid/in_ready - source beat handshake
//   in_dest           - destination router, sampled on a packet's first beat
//   in_payload        - beat payload
//   in_last           - final beat of the packet
//   out_data          - flit {vc, dest, payload} to the router input port
//   out_valid         - one-cycle pulse per flit, no backpressure
//   credit_increment  - per-VC credit returns from the router
//   credit_count      - credits per VC, VC v at [v*CREDIT_BITS +: CREDIT_BITS]
//   active_vc         - VC bound to the current packet
//   credit_overflow   - sticky; any VC received a credit while full
module vc_flit_injector
    import vr_ni_pkg::*;
#(
    parameter  int NUM_VC         = 4,
    parameter  int BUF_DEPTH      = 4,
    parameter  int ROUTER_ID_BITS = 4,
    parameter  int FLIT_W         = `FLIT_DATA_WIDTH,
    localparam int VC_BITS        = $clog2(NUM_VC),
    localparam int CREDIT_BITS    = $clog2(BUF_DEPTH + 1),
    localparam int PAYLOAD_W      = FLIT_W - VC_BITS - ROUTER_ID_BITS
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [ROUTER_ID_BITS-1:0]     in_dest,
    input  logic [PAYLOAD_W-1:0]          in_payload,
    input  logic                          in_last,
    output logic [FLIT_W-1:0]             out_data,
    output logic                          out_valid,
    input  logic [NUM_VC-1:0]             credit_increment,
    output logic [NUM_VC*CREDIT_BITS-1:0] credit_count,
    output logic [VC_BITS-1:0]            active_vc,
    output logic                          credit_overflow
);

    localparam int DEST_LSB = PAYLOAD_W;
    localparam int VC_LSB   = FLIT_W - VC_BITS;

    state_t                    state, state_next;
    logic [VC_BITS-1:0]        rr_ptr;
    logic [ROUTER_ID_BITS-1:0] dest_q;
    logic                      accept;
    logic                      pick_found;
    logic [VC_BITS-1:0]        pick_vc;
    logic [CREDIT_BITS-1:0]    credit [NUM_VC];
    logic [NUM_VC-1:0]         has_credit;
    logic [NUM_VC-1:0]         send_dec;
    logic [NUM_VC-1:0]         ovf;
    logic                      vld_p1;
    logic [FLIT_W-1:0]         flit_p1;

    for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
        vc_credit_counter #(
            .BUF_DEPTH   (BUF_DEPTH),
            .CREDIT_BITS (CREDIT_BITS)
        ) u_cnt (
            .clk      (clk),
            .reset_n  (reset_n),
            .inc      (credit_increment[v]),
            .dec      (send_dec[v]),
            .count    (credit[v]),
            .overflow (ovf[v])
        );
        assign has_credit[v] = (credit[v] != '0);
        assign send_dec[v]   = accept && (active_vc == VC_BITS'(v));
        assign credit_count[v*CREDIT_BITS +: CREDIT_BITS] = credit[v];
    end

    assign credit_overflow = |ovf;

    // Round-robin pick: first VC with credit starting just after the last one used.
    always_comb begin
        int                 idx;
        logic [VC_BITS-1:0] idx_v;
        pick_found = 1'b0;
        pick_vc    = '0;
        idx        = 0;
        idx_v      = '0;
        for (int i = 1; i <= NUM_VC; i++) begin
            idx   = (int'(rr_ptr) + i) % NUM_VC;
            idx_v = VC_BITS'(idx);
            if (!pick_found && has_credit[idx_v]) begin
                pick_found = 1'b1;
                pick_vc    = idx_v;
            end
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid && pick_found) state_next = SEND;
            end
            SEND: begin
                // Registered count only, so a credit returned at zero is usable next cycle.
                in_ready = (credit[active_vc] != '0);
                accept   = in_valid && in_ready;
                if (accept && in_last) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            rr_ptr    <= VC_BITS'(NUM_VC - 1);
            active_vc <= '0;
            dest_q    <= '0;
        end else begin
            state <= state_next;
            if ((state == IDLE) && in_valid && pick_found) begin
                active_vc <= pick_vc;
                dest_q    <= in_dest;
            end
            if (accept && in_last) rr_ptr <= active_vc;
        end
    end

    // Stage p0 -> p1: accepted beat becomes the registered flit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p1  <= 1'b0;
            flit_p1 <= '0;
        end else begin
            vld_p1  <= accept;
            flit_p1 <= accept ? FLIT_W'(pack_flit(PACK_MAX_W'(active_vc), PACK_MAX_W'(dest_q),
                                                  PACK_MAX_W'(in_payload), DEST_LSB, VC_LSB))
                              : '0;
        end
    end

    assign out_valid = vld_p1;
    assign out_data  = flit_p1;

endmodule

// File: tb/tb_vc_flit_injector.sv
// Self-checking bench for vc_flit_injector (default parameters, 32-bit flits).
module tb_vc_flit_injector;

    localparam int PW = 26;

    logic          clk;
    logic          reset_n;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_dest;
    logic [PW-1:0] in_payload;
    logic          in_last;
    logic [31:0]   out_data;
    logic          out_valid;
    logic [3:0]    credit_increment;
    logic [11:0]   credit_count;
    logic [1:0]    active_vc;
    logic          credit_overflow;

    int checks   = 0;
    int errors   = 0;
    int flit_cnt = 0;
    logic [31:0] exp_q [$];

    vc_flit_injector dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_dest          (in_dest),
        .in_payload       (in_payload),
        .in_last          (in_last),
        .out_data         (out_data),
        .out_valid        (out_valid),
        .credit_increment (credit_increment),
        .credit_count     (credit_count),
        .active_vc        (active_vc),
        .credit_overflow  (credit_overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] mk_flit(input logic [1:0] vc, input logic [3:0] dest,
                                            input logic [PW-1:0] pl);
        return {vc, dest, pl};
    endfunction

    function automatic logic [2:0] cred(input int v);
        return credit_count[v*3 +: 3];
    endfunction

    // Scoreboard: pop and compare every flit the DUT emits.
    always @(negedge clk) begin
        if (reset_n && out_valid) begin
            logic [31:0] exp;
            flit_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_flit: got %h, none expected", out_data);
            end else begin
                exp = exp_q.pop_front();
                if (out_data !== exp) begin
                    errors++;
                    $display("FAIL flit_data: got %h, expected %h", out_data, exp);
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset_n          = 1'b0;
        in_valid         = 1'b0;
        in_last          = 1'b0;
        credit_increment = '0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        exp_q.delete();
    endtask

    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic drive_beat(input logic [3:0] dest, input logic [PW-1:0] pl, input logic last,
                              input logic [1:0] exp_vc, input logic [3:0] exp_dest,
                              input int budget, output bit ok);
        in_valid   = 1'b1;
        in_dest    = dest;
        in_payload = pl;
        in_last    = last;
        ok         = 1'b0;
        for (int c = 0; c < budget && !ok; c++) begin
            #1;
            if (in_ready) begin
                ok = 1'b1;
                exp_q.push_back(mk_flit(exp_vc, exp_dest, pl));
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL beat_accept: not accepted within %0d cycles, expected accept", budget);
        end
    endtask

    task automatic send_packet(input logic [3:0] dest, input int n, input logic [1:0] exp_vc);
        bit ok;
        for (int b = 0; b < n; b++) begin
            logic [3:0] d;
            d = (b == 0) ? dest : 4'($urandom);
            drive_beat(d, PW'($urandom), (b == n - 1), exp_vc, dest, 4, ok);
            if (!ok) break;
        end
    endtask

    task automatic drain_check(input string name);
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d flits outstanding, expected 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        for (int v = 0; v < 4; v++) begin
            checks++;
            if (cred(v) !== 3'd4) begin
                errors++;
                $display("FAIL reset_credit%0d: got %0d, expected 4", v, cred(v));
            end
        end
        checks++;
        if (out_valid !== 1'b0 || out_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_out: valid %b data %h, expected 0 0", out_valid, out_data);
        end
        checks++;
        if (in_ready !== 1'b0 || credit_overflow !== 1'b0 || active_vc !== 2'd0) begin
            errors++;
            $display("FAIL reset_ctrl: ready %b ovf %b vc %0d, expected 0 0 0",
                     in_ready, credit_overflow, active_vc);
        end
        @(negedge clk);
    endtask

    task automatic test_single_beat();
        bit ok;
        int f0;
        do_reset();
        f0 = flit_cnt;
        drive_beat(4'd5, PW'(26'h1A), 1'b1, 2'd0, 4'd5, 4, ok);
        repeat (2) @(negedge clk);
        checks++;
        if (flit_cnt - f0 != 1) begin
            errors++;
            $display("FAIL single_count: got %0d flits, expected 1", flit_cnt - f0);
        end
        checks++;
        if (cred(0) !== 3'd3) begin
            errors++;
            $display("FAIL single_credit0: got %0d, expected 3", cred(0));
        end
        drain_check("single");
    endtask

    task automatic test_credit_stall();
        bit ok;
        int f0;
        do_reset();
        f0 = flit_cnt;
        for (int b = 0; b < 4; b++) drive_beat(4'd7, PW'($urandom), 1'b0, 2'd0, 4'd7, 4, ok);
        in_valid   = 1'b1;
        in_payload = PW'($urandom);
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_ready: got %b, expected 0", in_ready);
            end
            @(negedge clk);
        end
        checks++;
        if (cred(0) !== 3'd0 || flit_cnt - f0 != 4) begin
            errors++;
            $display("FAIL stall_state: credit0 %0d flits %0d, expected 0 4", cred(0), flit_cnt - f0);
        end
        credit_increment = 4'b0001;
        @(negedge clk);
        credit_increment = 4'b0000;
        drive_beat(4'd3, PW'($urandom), 1'b0, 2'd0, 4'd7, 1, ok);
        in_valid   = 1'b1;
        in_last    = 1'b1;
        in_payload = PW'($urandom);
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_after_return_ready: got %b, expected 0", in_ready);
            end
            @(negedge clk);
        end
        checks++;
        if (flit_cnt - f0 != 5 || cred(0) !== 3'd0) begin
            errors++;
            $display("FAIL stall_return: flits %0d credit0 %0d, expected 5 0", flit_cnt - f0, cred(0));
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        drain_check("stall");
    endtask

    task automatic test_round_robin();
        do_reset();
        send_packet(4'd1, 1, 2'd0);
        send_packet(4'd2, 4, 2'd1);
        send_packet(4'd3, 1, 2'd2);
        send_packet(4'd4, 1, 2'd3);
        send_packet(4'd5, 1, 2'd0);
        @(negedge clk);
        checks++;
        if (cred(1) !== 3'd0) begin
            errors++;
            $display("FAIL rr_credit1: got %0d, expected 0", cred(1));
        end
        send_packet(4'd6, 2, 2'd2);
        checks++;
        if (active_vc !== 2'd2) begin
            errors++;
            $display("FAIL rr_active_vc: got %0d, expected 2", active_vc);
        end
        drain_check("rr");
    endtask

    task automatic test_credit_edges();
        bit ok;
        do_reset();
        in_valid   = 1'b1;
        in_dest    = 4'd8;
        in_payload = PW'($urandom);
        in_last    = 1'b0;
        @(negedge clk);
        credit_increment = 4'b0001;
        #1;
        if (in_ready) exp_q.push_back(mk_flit(2'd0, 4'd8, in_payload));
        @(negedge clk);
        credit_increment = 4'b0000;
        checks++;
        if (cred(0) !== 3'd4 || credit_overflow !== 1'b0) begin
            errors++;
            $display("FAIL same_cycle: credit0 %0d ovf %b, expected 4 0", cred(0), credit_overflow);
        end
        drive_beat(4'd1, PW'($urandom), 1'b1, 2'd0, 4'd8, 4, ok);
        @(negedge clk);
        checks++;
        if (cred(0) !== 3'd3) begin
            errors++;
            $display("FAIL after_pkt_credit0: got %0d, expected 3", cred(0));
        end
        credit_increment = 4'b1000;
        @(negedge clk);
        credit_increment = 4'b0000;
        checks++;
        if (cred(3) !== 3'd4 || credit_overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow: credit3 %0d ovf %b, expected 4 1", cred(3), credit_overflow);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (credit_overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_sticky: got %b, expected 1", credit_overflow);
        end
        drain_check("edges");
    endtask

    task automatic test_reset_mid_packet();
        bit ok;
        do_reset();
        drive_beat(4'd9, PW'($urandom), 1'b0, 2'd0, 4'd9, 4, ok);
        in_valid   = 1'b1;
        in_payload = PW'($urandom);
        #1;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_first_flit: out_valid %b, expected 1", out_valid);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || credit_count !== 12'h924) begin
            errors++;
            $display("FAIL mid_reset: valid %b ready %b credits %h, expected 0 0 924",
                     out_valid, in_ready, credit_count);
        end
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        exp_q.delete();
        send_packet(4'd2, 1, 2'd0);
        checks++;
        if (active_vc !== 2'd0) begin
            errors++;
            $display("FAIL mid_next_vc: got %0d, expected 0", active_vc);
        end
        drain_check("mid");
    endtask

    initial begin
        reset_n          = 1'b0;
        in_valid         = 1'b0;
        in_dest          = '0;
        in_payload       = '0;
        in_last          = 1'b0;
        credit_increment = '0;
        test_reset();
        test_single_beat();
        test_credit_stall();
        test_round_robin();
        test_credit_edges();
        test_reset_mid_packet();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
